// File: rtl/bcd_alu_seq_if.sv
// bcd_alu_seq_if: start/done request bundle for bcd_alu_seq; rem_bcd exists only with BCD_ALU_REM_EN
interface bcd_alu_seq_if #(parameter int DIGITS = 4);
  logic start;
  logic [4*DIGITS-1:0] num1_bcd;
  logic [4*DIGITS-1:0] num2_bcd;
  logic [1:0] operation;
  logic busy;
  logic done;
  logic [4*DIGITS-1:0] result;
  logic neg;
  logic ovf;
  logic err;
`ifdef BCD_ALU_REM_EN
  logic [4*DIGITS-1:0] rem_bcd;
  modport master (
    output start, num1_bcd, num2_bcd, operation,
    input  busy, done, result, neg, ovf, err, rem_bcd
  );
  modport slave (
    input  start, num1_bcd, num2_bcd, operation,
    output busy, done, result, neg, ovf, err, rem_bcd
  );
`else
  modport master (
    output start, num1_bcd, num2_bcd, operation,
    input  busy, done, result, neg, ovf, err
  );
  modport slave (
    input  start, num1_bcd, num2_bcd, operation,
    output busy, done, result, neg, ovf, err
  );
`endif
endinterface

// File: rtl/bcd_alu_seq.sv
// bcd_alu_seq: digit-serial BCD add/sub/mul/div sequencer; BCD_ALU_REM_EN adds the rem_bcd output
module bcd_alu_seq #(
  parameter int DIGITS = 4
) (
  input logic clk,
  input logic rst,
  bcd_alu_seq_if.slave bus
);
  localparam int W = 4 * DIGITS;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);
  localparam logic [1:0] OP_ADD = 2'd0, OP_SUB = 2'd1, OP_MUL = 2'd2, OP_DIV = 2'd3;
  typedef enum logic [2:0] {IDLE, CHECK, DIG, DCMP, FIN} state_t;
  state_t state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [IW-1:0] idx_q, idx_d;
  logic c_q, c_d, neg_q, neg_d, ovf_q, ovf_d, err_q, err_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, cnt_q, cnt_d;
  logic [W-1:0] quot_q, quot_d, rem_q, rem_d, tmp_q, tmp_d, result_q, result_d;
  logic [W-1:0] x_w, y_w, full_w, cnt_dec;
  logic [3:0] xd, yd, dig_w;
  logic [4:0] sum_w;
  logic sub_w, cout_w;
`ifdef BCD_ALU_REM_EN
  logic [W-1:0] rem_bcd_q, rem_bcd_d;
  assign bus.rem_bcd = rem_bcd_q;
`endif
  function automatic logic bad_bcd(input logic [W-1:0] v);
    bad_bcd = 1'b0;
    for (int i = 0; i < DIGITS; i++) bad_bcd = bad_bcd | (v[4*i +: 4] > 4'd9);
  endfunction
  function automatic logic [W-1:0] bcd_step(input logic [W-1:0] v, input logic up);
    logic go, wrap;
    bcd_step = v;
    go = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      wrap = up ? (v[4*i +: 4] == 4'd9) : (v[4*i +: 4] == 4'd0);
      if (go) bcd_step[4*i +: 4] = wrap ? (up ? 4'd0 : 4'd9) : (up ? v[4*i +: 4] + 4'd1 : v[4*i +: 4] - 4'd1);
      go = go & wrap;
    end
  endfunction
  // the shared digit unit: mul accumulates A into acc, div subtracts B from rem
  assign sub_w = (op_q == OP_SUB) || (op_q == OP_DIV);
  assign x_w = op_q == OP_MUL ? acc_q : op_q == OP_DIV ? rem_q : a_q;
  assign y_w = op_q == OP_MUL ? a_q : b_q;
  assign xd = x_w[4*idx_q +: 4];
  assign yd = y_w[4*idx_q +: 4];
  assign sum_w = sub_w ? {1'b0, xd} - {1'b0, yd} - {4'b0, c_q} : {1'b0, xd} + {1'b0, yd} + {4'b0, c_q};
  assign cout_w = sub_w ? sum_w[4] : (sum_w > 5'd9);
  assign dig_w = sum_w[3:0] + (cout_w ? (sub_w ? 4'd10 : 4'd6) : 4'd0);
  assign cnt_dec = bcd_step(cnt_q, 1'b0);
  always_comb begin
    full_w = tmp_q;
    full_w[4*idx_q +: 4] = dig_w;
  end
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    idx_d = idx_q;
    c_d = c_q;
    neg_d = neg_q;
    ovf_d = ovf_q;
    err_d = err_q;
    a_d = a_q;
    b_d = b_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    quot_d = quot_q;
    rem_d = rem_q;
    tmp_d = tmp_q;
    result_d = result_q;
`ifdef BCD_ALU_REM_EN
    rem_bcd_d = rem_bcd_q;
`endif
    case (state_q)
      IDLE: if (bus.start) begin
        a_d = bus.num1_bcd;
        b_d = bus.num2_bcd;
        op_d = bus.operation;
        neg_d = 1'b0;
        ovf_d = 1'b0;
        err_d = 1'b0;
        result_d = '0;
`ifdef BCD_ALU_REM_EN
        rem_bcd_d = '0;
`endif
        state_d = CHECK;
      end
      CHECK: begin
        idx_d = '0;
        c_d = 1'b0;
        acc_d = '0;
        cnt_d = b_q;
        quot_d = '0;
        rem_d = a_q;
        state_d = DIG;
        if (bad_bcd(a_q) || bad_bcd(b_q)) begin
          err_d = 1'b1;
          state_d = FIN;
        end else if (op_q[1] && b_q == '0) begin
          err_d = op_q[0];
          state_d = FIN;
        end else if (op_q == OP_DIV) state_d = DCMP;
        else if (op_q == OP_SUB && a_q < b_q) begin
          a_d = b_q;
          b_d = a_q;
          neg_d = 1'b1;
        end
      end
      DIG: begin
        tmp_d = full_w;
        c_d = cout_w;
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST) begin
          idx_d = '0;
          c_d = 1'b0;
          if (op_q == OP_DIV) begin
            rem_d = full_w;
            quot_d = bcd_step(quot_q, 1'b1);
            state_d = DCMP;
          end else if (op_q == OP_MUL) begin
            acc_d = full_w;
            cnt_d = cnt_dec;
            ovf_d = ovf_q | cout_w;
            result_d = cnt_dec == '0 ? full_w : result_q;
            state_d = cnt_dec == '0 ? FIN : DIG;
          end else begin
            result_d = full_w;
            ovf_d = (op_q == OP_ADD) & cout_w;
            state_d = FIN;
          end
        end
      end
      DCMP: if (rem_q < b_q) begin
        result_d = quot_q;
`ifdef BCD_ALU_REM_EN
        rem_bcd_d = rem_q;
`endif
        state_d = FIN;
      end else state_d = DIG;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      op_q <= '0;
      idx_q <= '0;
      c_q <= 1'b0;
      neg_q <= 1'b0;
      ovf_q <= 1'b0;
      err_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      quot_q <= '0;
      rem_q <= '0;
      tmp_q <= '0;
      result_q <= '0;
`ifdef BCD_ALU_REM_EN
      rem_bcd_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      idx_q <= idx_d;
      c_q <= c_d;
      neg_q <= neg_d;
      ovf_q <= ovf_d;
      err_q <= err_d;
      a_q <= a_d;
      b_q <= b_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      quot_q <= quot_d;
      rem_q <= rem_d;
      tmp_q <= tmp_d;
      result_q <= result_d;
`ifdef BCD_ALU_REM_EN
      rem_bcd_q <= rem_bcd_d;
`endif
    end
  end
  assign bus.busy = state_q != IDLE;
  assign bus.done = state_q == FIN;
  assign bus.result = result_q;
  assign bus.neg = neg_q;
  assign bus.ovf = ovf_q;
  assign bus.err = err_q;
endmodule

// File: tb/tb_bcd_alu_seq.sv
// tb_bcd_alu_seq: scoreboard bench for bcd_alu_seq, checks values, flags, latency and abort-by-reset
module tb_bcd_alu_seq;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  bcd_alu_seq_if bus ();
  bcd_alu_seq dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct packed {
    logic [15:0] res;
    logic neg;
    logic ovf;
    logic err;
    logic [15:0] rem;
    logic [31:0] lat;
  } exp_t;
  exp_t sb[$];
  int compared = 0;
  int mismatched = 0;
  function automatic int bcd2int(input logic [15:0] v);
    return v[15:12] * 1000 + v[11:8] * 100 + v[7:4] * 10 + v[3:0];
  endfunction
  function automatic logic [15:0] int2bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction
  function automatic bit bad(input logic [15:0] v);
    return v[15:12] > 9 || v[11:8] > 9 || v[7:4] > 9 || v[3:0] > 9;
  endfunction
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
    exp_t e;
    int ai, bi, r;
    e = '0;
    ai = bcd2int(a);
    bi = bcd2int(b);
    if (bad(a) || bad(b)) begin
      e.err = 1'b1;
      e.lat = 1;
      return e;
    end
    case (op)
      2'd0: begin r = ai + bi; e.ovf = r > 9999; e.res = int2bcd(r % 10000); e.lat = 5; end
      2'd1: begin e.neg = ai < bi; e.res = int2bcd(ai < bi ? bi - ai : ai - bi); e.lat = 5; end
      2'd2: if (bi == 0) e.lat = 1;
            else begin r = ai * bi; e.ovf = r > 9999; e.res = int2bcd(r % 10000); e.lat = 1 + 4 * bi; end
      default: if (bi == 0) begin e.err = 1'b1; e.lat = 1; end
               else begin e.res = int2bcd(ai / bi); e.rem = int2bcd(ai % bi); e.lat = 2 + 5 * (ai / bi); end
    endcase
    return e;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, " busy"}, 32'(bus.busy), 0);
    chk({tag, " done"}, 32'(bus.done), 0);
    chk({tag, " result"}, 32'(bus.result), 0);
    chk({tag, " neg"}, 32'(bus.neg), 0);
    chk({tag, " ovf"}, 32'(bus.ovf), 0);
    chk({tag, " err"}, 32'(bus.err), 0);
`ifdef BCD_ALU_REM_EN
    chk({tag, " rem"}, 32'(bus.rem_bcd), 0);
`endif
  endtask
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [1:0] op, input bit poke);
    exp_t e;
    int n;
    sb.push_back(model(a, b, op));
    @(negedge clk);
    bus.num1_bcd = a;
    bus.num2_bcd = b;
    bus.operation = op;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.num1_bcd = 16'($urandom);
    bus.num2_bcd = 16'($urandom);
    bus.operation = 2'($urandom);
    n = 0;
    while (!bus.done && n < 60000) begin
      @(posedge clk);
      n++;
      #1;
      if (poke) bus.start = (n == 2);
    end
    bus.start = 1'b0;
    e = sb.pop_front();
    chk({tag, " latency"}, n, e.lat);
    chk({tag, " result"}, 32'(bus.result), 32'(e.res));
    chk({tag, " neg"}, 32'(bus.neg), 32'(e.neg));
    chk({tag, " ovf"}, 32'(bus.ovf), 32'(e.ovf));
    chk({tag, " err"}, 32'(bus.err), 32'(e.err));
`ifdef BCD_ALU_REM_EN
    chk({tag, " rem"}, 32'(bus.rem_bcd), 32'(e.rem));
`endif
    if (poke) bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk({tag, " busy after FIN"}, 32'(bus.busy), 0);
    chk({tag, " done pulse"}, 32'(bus.done), 0);
    if (poke) begin
      @(posedge clk);
      #1;
      chk({tag, " start in FIN ignored"}, 32'(bus.busy), 0);
    end
  endtask
  initial begin
    int ra, rb;
    logic seen;
    bus.start = 1'b0;
    bus.num1_bcd = '0;
    bus.num2_bcd = '0;
    bus.operation = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle("reset");
    @(negedge clk);
    rst = 1'b1;
    run_op("add 456+789", 16'h0456, 16'h0789, 2'd0, 1'b1);
    run_op("sub 12-345", 16'h0012, 16'h0345, 2'd1, 1'b0);
    run_op("sub 345-345", 16'h0345, 16'h0345, 2'd1, 1'b0);
    run_op("add 9999+1", 16'h9999, 16'h0001, 2'd0, 1'b0);
    run_op("bad num1", 16'h0A12, 16'h0003, 2'd0, 1'b0);
    run_op("bad num2 sub", 16'h0100, 16'h00F0, 2'd1, 1'b0);
    run_op("mul 12*3", 16'h0012, 16'h0003, 2'd2, 1'b1);
    run_op("mul 500*30", 16'h0500, 16'h0030, 2'd2, 1'b0);
    run_op("mul by zero", 16'h1234, 16'h0000, 2'd2, 1'b0);
    run_op("div 100/7", 16'h0100, 16'h0007, 2'd3, 1'b1);
    @(negedge clk);
    bus.num1_bcd = 16'h0001;
    bus.num2_bcd = 16'h0050;
    bus.operation = 2'd2;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    chk("abort busy before reset", 32'(bus.busy), 1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_idle("abort");
    rst = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      seen = seen | bus.done | bus.busy;
    end
    chk("abort no done", 32'(seen), 0);
    run_op("div 5/0", 16'h0005, 16'h0000, 2'd3, 1'b0);
    run_op("div 9/3", 16'h0009, 16'h0003, 2'd3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      ra = int'($urandom_range(0, 9999));
      rb = int'($urandom_range(0, 9999));
      run_op((i % 2) ? "rand sub" : "rand add", int2bcd(ra), int2bcd(rb), 2'(i % 2), 1'b0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
